if_id_stage: RTL and testbench

//  Instruction fetch stage plus IF/ID pipeline register of the 32-bit processor.

---
 rtl/if_id_stage_if.sv | 11 +
 rtl/if_id_stage.sv | 150 +++++++++++++++
 tb/tb_if_id_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/if_id_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and instruction memory (slave).
// The master holds imem_req and keeps imem_addr stable until the memory returns imem_ack.
interface if_id_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/if_id_stage.sv
// Instruction fetch stage and IF/ID pipeline register.
// It holds the PC and fetches over a req/ack bus. A one-entry hold buffer absorbs a
// word that returns while decode is stalled. Redirects from branch/jump logic take
// priority over stall and ack.
// Build option: define BRANCH_DELAY_SLOT_EN to let the instruction in ID survive a
// redirect as a delay slot. When it is undefined, a redirect squashes that instruction.
//
// state   | meaning
// BOOT    | idle cycle after reset, no request
// FETCH   | request pending at pc, waiting for ack
// HOLD    | fetched word parked in hold buffer until decode frees up
// DISCARD | redirected while a request was pending; drop the stale word
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    if_id_stage_if.master        imem,
    input  logic                 stall,
    input  logic                 redirect_en,
    input  logic [31:0]          redirect_pc,
    output logic                 id_valid,
    output logic [31:0]          id_instr,
    output logic [31:0]          id_pc_plus4,
    output logic [5:0]           id_opcode,
    output logic [4:0]           id_rs,
    output logic [4:0]           id_rt,
    output logic [4:0]           id_rd,
    output logic [4:0]           id_shamt,
    output logic [5:0]           id_funct,
    output logic [15:0]          id_imm16,
    output logic [25:0]          id_jtarget
);

    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DISCARD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt, pc_inc;
    logic        req_q;
    logic [31:0] addr_q;
    logic [31:0] hold_instr, hold_pc4;
    logic        load_fetch, load_hold, to_hold;

    assign pc_inc         = pc + PC_STEP;
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    // Next-state, next-PC and ID-load decisions; redirect overrides everything else.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        load_fetch = 1'b0;
        load_hold  = 1'b0;
        to_hold    = 1'b0;
        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH: begin
                if (imem.imem_ack) begin
                    pc_nxt = pc_inc;
                    if (stall && id_valid) begin
                        to_hold   = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        load_fetch = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    load_hold = 1'b1;
                    state_nxt = FETCH;
                end
            end
            DISCARD: begin
                if (imem.imem_ack)
                    state_nxt = FETCH;
            end
            default: state_nxt = BOOT;
        endcase
        if (redirect_en) begin
            pc_nxt     = {redirect_pc[31:2], 2'b00};
            load_fetch = 1'b0;
            load_hold  = 1'b0;
            to_hold    = 1'b0;
            if (state == FETCH)
                state_nxt = imem.imem_ack ? FETCH : DISCARD;
            else if (state == HOLD)
                state_nxt = FETCH;
        end
    end

    // FSM state, PC, registered request/address, hold buffer and ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            hold_instr  <= '0;
            hold_pc4    <= '0;
            id_valid    <= 1'b0;
            id_instr    <= '0;
            id_pc_plus4 <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            req_q <= (state_nxt == FETCH) || (state_nxt == DISCARD);
            // A discarded request must keep its original address until acked.
            if (state_nxt != DISCARD)
                addr_q <= pc_nxt;

            if (to_hold) begin
                hold_instr <= imem.imem_rdata;
                hold_pc4   <= pc_inc;
            end else if (redirect_en) begin
                hold_instr <= '0;
                hold_pc4   <= '0;
            end

            if (load_fetch) begin
                id_valid    <= 1'b1;
                id_instr    <= imem.imem_rdata;
                id_pc_plus4 <= pc_inc;
            end else if (load_hold) begin
                id_valid    <= 1'b1;
                id_instr    <= hold_instr;
                id_pc_plus4 <= hold_pc4;
            end else if (redirect_en) begin
`ifdef BRANCH_DELAY_SLOT_EN
                id_valid <= id_valid;
`else
                id_valid <= 1'b0;
`endif
            end else if (!stall) begin
                id_valid <= 1'b0;
            end
        end
    end

    assign id_opcode  = id_instr[31:26];
    assign id_rs      = id_instr[25:21];
    assign id_rt      = id_instr[20:16];
    assign id_rd      = id_instr[15:11];
    assign id_shamt   = id_instr[10:6];
    assign id_funct   = id_instr[5:0];
    assign id_imm16   = id_instr[15:0];
    assign id_jtarget = id_instr[25:0];

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized bench for if_id_stage. The reference model is transaction-level. It tracks
// the outstanding fetch, whether that fetch is stale, the hold buffer and the ID
// contents. Each cycle it predicts the fetch bus and the ID outputs.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect_en;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_instr, id_pc_plus4;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [15:0] id_imm16;
    logic [25:0] id_jtarget;

    int n_checks = 0;
    int n_fail   = 0;

    if_id_stage_if imem_bus ();

    if_id_stage dut (
        .clk(clk), .rst(rst), .imem(imem_bus.master),
        .stall(stall), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_shamt(id_shamt), .id_funct(id_funct), .id_imm16(id_imm16),
        .id_jtarget(id_jtarget)
    );

    always #5 clk = ~clk;

    // model state
    bit          m_req, m_drop, m_buf_v, m_vld;
    logic [31:0] m_addr, m_pc, m_buf_instr, m_buf_pc4, m_instr, m_pc4;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h2008_FFFF;
    endfunction

    task automatic model_reset();
        m_req = 0; m_drop = 0; m_buf_v = 0; m_vld = 0;
        m_addr = 32'h0; m_pc = 32'h0;
        m_buf_instr = 32'h0; m_buf_pc4 = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
    endtask

    task automatic model_step(input bit st, input bit rd, input logic [31:0] rpc,
                              input bit ack, input logic [31:0] rdata);
        bit delivered, fresh, id_free;
        delivered = m_req && ack;
        fresh     = delivered && !m_drop;
        id_free   = !(st && m_vld);
        // decode side
        if (rd) begin
`ifndef BRANCH_DELAY_SLOT_EN
            m_vld = 0;
`endif
            m_buf_v = 0;
        end else if (m_buf_v) begin
            if (!st) begin
                m_vld = 1; m_instr = m_buf_instr; m_pc4 = m_buf_pc4; m_buf_v = 0;
            end
        end else if (fresh) begin
            if (id_free) begin
                m_vld = 1; m_instr = rdata; m_pc4 = m_addr + 32'd4;
            end else begin
                m_buf_v = 1; m_buf_instr = rdata; m_buf_pc4 = m_addr + 32'd4;
            end
        end else if (!st) begin
            m_vld = 0;
        end
        // fetch side
        if (fresh) m_pc = m_addr + 32'd4;
        if (delivered) begin m_req = 0; m_drop = 0; end
        if (rd) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            if (m_req) m_drop = 1;
        end
        if (!m_req && !m_buf_v) begin
            m_req = 1; m_addr = m_pc;
        end
    endtask

    task automatic check_outputs();
        check_val("imem_req", 32'(imem_bus.imem_req), 32'(m_req));
        if (m_req) check_val("imem_addr", imem_bus.imem_addr, m_addr);
        check_val("id_valid", 32'(id_valid), 32'(m_vld));
        check_val("id_instr", id_instr, m_instr);
        check_val("id_pc_plus4", id_pc_plus4, m_pc4);
        check_val("id_opcode", 32'(id_opcode), (m_instr >> 26) & 32'h3F);
        check_val("id_rs", 32'(id_rs), (m_instr >> 21) & 32'h1F);
        check_val("id_rt", 32'(id_rt), (m_instr >> 16) & 32'h1F);
        check_val("id_rd", 32'(id_rd), (m_instr >> 11) & 32'h1F);
        check_val("id_shamt", 32'(id_shamt), (m_instr >> 6) & 32'h1F);
        check_val("id_funct", 32'(id_funct), m_instr & 32'h3F);
        check_val("id_imm16", 32'(id_imm16), m_instr & 32'hFFFF);
        check_val("id_jtarget", 32'(id_jtarget), m_instr & 32'h03FF_FFFF);
    endtask

    initial begin
        bit          st, rd, ack, rst_cyc;
        logic [31:0] rpc, rdata;
        rst = 1'b1; stall = 0; redirect_en = 0; redirect_pc = 0;
        imem_bus.imem_ack = 0; imem_bus.imem_rdata = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (rst) rst = 1'b0;
            check_outputs();
            // after reset with ack every cycle: first word lands in ID two edges later
            if (cyc == 2) begin
                check_val("dir_opcode", 32'(id_opcode), 32'h08);
                check_val("dir_rs", 32'(id_rs), 32'h0);
                check_val("dir_rt", 32'(id_rt), 32'h8);
                check_val("dir_imm16", 32'(id_imm16), 32'hFFFF);
                check_val("dir_pc4", id_pc_plus4, 32'h4);
                check_val("dir_addr", imem_bus.imem_addr, 32'h4);
            end
            if (cyc < 6) begin
                st = 0; rd = 0; rpc = 0; ack = m_req;
            end else begin
                st  = ($urandom_range(0, 2) == 0);
                rd  = ($urandom_range(0, 9) == 0);
                rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                  : $urandom;
                ack = m_req ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            end
            rdata = m_req ? mem_word(m_addr) : $urandom;
            rst_cyc = (cyc > 20) && ($urandom_range(0, 199) == 0);
            stall = st; redirect_en = rd; redirect_pc = rpc;
            imem_bus.imem_ack = ack; imem_bus.imem_rdata = rdata;
            if (rst_cyc) begin
                rst = 1'b1;
                model_reset();
            end
            @(posedge clk);
            if (!rst_cyc) model_step(st, rd, rpc, ack, rdata);
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
